fft4_seq: RTL and testbench
===========================

FFT4_SEQ -- requirements
Module: fft4_seq

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset: one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  input sample valid.
REQ-005 in_ready  output  1  block can accept an input sample.
REQ-006 in_re, in_im  input  9 each  signed input sample, two's complement.
REQ-007 bf_ar, bf_ai  output  9 each  butterfly upper operand (drives butterfly inr/ini).
REQ-008 bf_br, bf_bi  output  9 each  butterfly lower operand (drives butterfly yr/yi).
REQ-009 bf_wr, bf_wi  output  9 each  butterfly twiddle, signed integer scale.
REQ-010 bf_s0r, bf_s0i, bf_s1r, bf_s1i  input  9 each  combinational butterfly results: sum (s0) and difference (s1).
REQ-011 out_valid  output  1  output bin valid.
REQ-012 out_ready  input  1  downstream accepts an output bin.
REQ-013 out_re, out_im  output  9 each  signed output bin.
REQ-014 busy  output  1  high in CALC and DRAIN.
REQ-015 frame_done  output  1  one-cycle pulse on acceptance of the last output bin.

Function
REQ-016 SHALL compute a 4-point DIT FFT by time-sharing one external radix-2 butterfly, one butterfly per clock.
REQ-017 SHALL hold a 4-entry complex buffer buf[0..3], 9-bit real and 9-bit imaginary per entry.
REQ-018 SHALL use states LOAD, CALC and DRAIN, plus a 2-bit counter cnt.
REQ-019 LOAD: in_ready=1; each in_valid&in_ready beat writes buf[cnt] and increments cnt; the 4th beat (cnt=3) moves to CALC with cnt=0.
REQ-020 CALC: in_ready=0 and out_valid=0; one butterfly per cycle; buf writeback on each clock edge; after cnt=3 moves to DRAIN with cnt=0.
REQ-021 CALC step 0: a=buf0, b=buf2, w=(1,0); buf0<=s0, buf2<=s1.
REQ-022 CALC step 1: a=buf1, b=buf3, w=(1,0); buf1<=s0, buf3<=s1.
REQ-023 CALC step 2: a=buf0, b=buf1, w=(1,0); buf0<=s0, buf1<=s1.
REQ-024 CALC step 3: a=buf2, b=buf3, w=(0,-1); buf2<=s0, buf3<=s1.
REQ-025 Outside CALC, bf_* outputs SHALL be 0; the butterfly results SHALL be ignored.
REQ-026 DRAIN: out_valid=1; bins SHALL be emitted in natural order X0..X3 from buf[0], buf[2], buf[1], buf[3]; cnt advances only on out_valid&out_ready.
REQ-027 While out_ready=0, out_re/out_im SHALL be held stable.
REQ-028 The 4th accepted output SHALL pulse frame_done and return to LOAD with cnt=0; in_ready SHALL be 1 on the next cycle.
REQ-029 Latency: the first output is valid exactly 4 cycles after the clock edge accepting x3.
REQ-030 Arithmetic SHALL be 9-bit two's-complement wrap-around with no saturation; the block performs no arithmetic itself.
REQ-031 in_valid SHALL be ignored outside LOAD; out_ready SHALL be ignored outside DRAIN.

Reset
REQ-032 rst_n=0 SHALL immediately force state=LOAD, cnt=0, buf=0, in_ready=1, out_valid=0, busy=0, frame_done=0, and out_*=0, bf_*=0.
REQ-033 Reset asserted mid-LOAD, CALC or DRAIN SHALL discard the partial frame; after release, the next accepted sample is x0.

Verification
REQ-034 Impulse x=(1,0,0,0) -> X0..X3 all (1,0); first out_valid 4 cycles after x3.
REQ-035 x=(0,1,0,0) -> X0=(1,0), X1=(0,-1), X2=(-1,0), X3=(0,1).
REQ-036 DC x=(100,100,100,100) -> X0=(-112,0) (400 wrapped), X1=X2=X3=(0,0).
REQ-037 Backpressure: out_ready=0 for 3 cycles during X1 -> X1 held stable, no bin skipped or duplicated, frame_done only after X3.
REQ-038 Reset pulse during CALC step 2, then new frame (2,0,0,0) -> outputs all (2,0); in_valid gaps during LOAD do not shift sample indices.
REQ-039 Back-to-back frames with in_valid held high -> in_ready=0 throughout CALC/DRAIN, and the second frame's x0 is accepted the cycle after frame_done.

Source files
------------

// File: rtl/fft4_seq.sv
// 4-point DIT FFT sequencer: loads four complex samples, drives one external
// radix-2 butterfly per clock for four steps, then drains bins in natural order.
module fft4_seq #(
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic [DATA_W-1:0] bf_ar,
    output logic [DATA_W-1:0] bf_ai,
    output logic [DATA_W-1:0] bf_br,
    output logic [DATA_W-1:0] bf_bi,
    output logic [DATA_W-1:0] bf_wr,
    output logic [DATA_W-1:0] bf_wi,
    input  logic [DATA_W-1:0] bf_s0r,
    input  logic [DATA_W-1:0] bf_s0i,
    input  logic [DATA_W-1:0] bf_s1r,
    input  logic [DATA_W-1:0] bf_s1i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;

    state_t state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic [1:0] idx_a, idx_b;
    logic signed [DATA_W-1:0] fbuf_re [4];
    logic signed [DATA_W-1:0] fbuf_im [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        idx_a      = 2'd0;
        idx_b      = 2'd0;
        bf_ar      = '0;
        bf_ai      = '0;
        bf_br      = '0;
        bf_bi      = '0;
        bf_wr      = '0;
        bf_wi      = '0;
        out_re     = '0;
        out_im     = '0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_nxt = cnt + 2'd1;
                    if (cnt == 2'd3) state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                // Steps 0-1 pair entries two apart, steps 2-3 pair neighbours; only the last uses -j.
                case (cnt)
                    2'd0:    begin idx_a = 2'd0; idx_b = 2'd2; end
                    2'd1:    begin idx_a = 2'd1; idx_b = 2'd3; end
                    2'd2:    begin idx_a = 2'd0; idx_b = 2'd1; end
                    default: begin idx_a = 2'd2; idx_b = 2'd3; end
                endcase
                bf_ar = fbuf_re[idx_a];
                bf_ai = fbuf_im[idx_a];
                bf_br = fbuf_re[idx_b];
                bf_bi = fbuf_im[idx_b];
                if (cnt == 2'd3) begin
                    bf_wr = '0;
                    bf_wi = '1;
                end else begin
                    bf_wr = DATA_W'(1);
                    bf_wi = '0;
                end
                cnt_nxt = cnt + 2'd1;
                if (cnt == 2'd3) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // Bit-reversed read gives natural bin order X0..X3.
                out_re    = fbuf_re[{cnt[0], cnt[1]}];
                out_im    = fbuf_im[{cnt[0], cnt[1]}];
                if (out_ready) begin
                    cnt_nxt = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        frame_done = 1'b1;
                        state_nxt  = LOAD;
                    end
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fbuf_re[i] <= '0;
                fbuf_im[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        fbuf_re[cnt] <= in_re;
                        fbuf_im[cnt] <= in_im;
                    end
                end
                CALC: begin
                    fbuf_re[idx_a] <= bf_s0r;
                    fbuf_im[idx_a] <= bf_s0i;
                    fbuf_re[idx_b] <= bf_s1r;
                    fbuf_im[idx_b] <= bf_s1i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft4_seq.sv
// Scoreboard bench for fft4_seq: an external butterfly model closes the loop,
// expected bins come from a direct 4-point DFT with 9-bit wrap.
module tb_fft4_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [8:0] in_re, in_im;
    logic [8:0] bf_ar, bf_ai, bf_br, bf_bi, bf_wr, bf_wi;
    logic [8:0] bf_s0r, bf_s0i, bf_s1r, bf_s1i;
    logic       out_valid, out_ready;
    logic [8:0] out_re, out_im;
    logic       busy, frame_done;

    always #5 clk = ~clk;

    fft4_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .bf_ar(bf_ar), .bf_ai(bf_ai), .bf_br(bf_br), .bf_bi(bf_bi),
        .bf_wr(bf_wr), .bf_wi(bf_wi),
        .bf_s0r(bf_s0r), .bf_s0i(bf_s0i), .bf_s1r(bf_s1r), .bf_s1i(bf_s1i),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .busy(busy), .frame_done(frame_done)
    );

    // External radix-2 butterfly: s0 = a + w*b, s1 = a - w*b, 9-bit wrap.
    always_comb begin
        int wbr, wbi;
        wbr = $signed(bf_wr) * $signed(bf_br) - $signed(bf_wi) * $signed(bf_bi);
        wbi = $signed(bf_wr) * $signed(bf_bi) + $signed(bf_wi) * $signed(bf_br);
        bf_s0r = 9'($signed(bf_ar) + wbr);
        bf_s0i = 9'($signed(bf_ai) + wbi);
        bf_s1r = 9'($signed(bf_ar) - wbr);
        bf_s1i = 9'($signed(bf_ai) - wbi);
    end

    typedef struct { logic [8:0] re; logic [8:0] im; } bin_t;
    bin_t exp_q[$];

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    int cyc_x3 = 0, fd_cyc = -10, acc_cyc = 0;
    bit lat_pending = 0, rnd_ready = 0;
    logic [8:0] cur_re [4];
    logic [8:0] cur_im [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Direct DFT: X[k] = sum x[n] * W^(k*n), W = -j.
    task automatic expect_frame();
        for (int k = 0; k < 4; k++) begin
            int sr, si, xr, xi;
            bin_t b;
            sr = 0; si = 0;
            for (int n = 0; n < 4; n++) begin
                xr = $signed(cur_re[n]);
                xi = $signed(cur_im[n]);
                case ((k * n) % 4)
                    0: begin sr += xr; si += xi; end
                    1: begin sr += xi; si -= xr; end
                    2: begin sr -= xr; si -= xi; end
                    default: begin sr -= xi; si += xr; end
                endcase
            end
            b.re = 9'(sr);
            b.im = 9'(si);
            exp_q.push_back(b);
        end
    endtask

    task automatic set_frame(input int r0, input int i0, input int r1, input int i1,
                             input int r2, input int i2, input int r3, input int i3);
        cur_re[0] = 9'(r0); cur_im[0] = 9'(i0);
        cur_re[1] = 9'(r1); cur_im[1] = 9'(i1);
        cur_re[2] = 9'(r2); cur_im[2] = 9'(i2);
        cur_re[3] = 9'(r3); cur_im[3] = 9'(i3);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 4; i++) begin
            cur_re[i] = 9'($urandom_range(0, 511));
            cur_im[i] = 9'($urandom_range(0, 511));
        end
    endtask

    // Entered and left on a falling edge.
    task automatic send_sample(input int idx, input bit hold);
        int bound;
        in_valid = 1'b1;
        in_re = cur_re[idx];
        in_im = cur_im[idx];
        bound = 0;
        while (!in_ready && bound < 200) begin
            @(negedge clk);
            bound++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        if (idx == 0) acc_cyc = cyc;
        if (idx == 3) begin
            cyc_x3 = cyc + 1;
            expect_frame();
            lat_pending = 1;
        end
        @(negedge clk);
        if (!hold) begin
            in_valid = 1'b0;
            in_re = 9'($urandom_range(0, 511));
            in_im = 9'($urandom_range(0, 511));
        end
    endtask

    task automatic send_frame(input bit gaps, input bit hold);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) @(negedge clk);
            end
            send_sample(i, hold);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_out_zero", int'(|{out_re, out_im}), 0);
        chk("rst_bf_zero", int'(|{bf_ar, bf_ai, bf_br, bf_bi, bf_wr, bf_wi}), 0);
        exp_q.delete();
        lat_pending = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int bound;
        bound = 0;
        while (!(exp_q.size() == 0 && in_ready) && bound < 300) begin
            @(negedge clk);
            bound++;
        end
        if (bound >= 300) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_out_valid();
        int bound;
        bound = 0;
        while (!out_valid && bound < 50) begin
            @(negedge clk);
            bound++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: samples 2 time units after the falling edge, well clear of the rising edge.
    initial begin
        int idx;
        bit pv, pr;
        logic [8:0] pre, pim;
        bin_t e;
        idx = 0; pv = 0; pr = 0; pre = '0; pim = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                idx = 0;
                pv = 0;
                continue;
            end
            chk("busy_vs_in_ready", busy, !in_ready);
            if (in_ready || out_valid)
                chk("bf_idle_zero", int'(|{bf_ar, bf_ai, bf_br, bf_bi, bf_wr, bf_wi}), 0);
            if (pv && !pr && out_valid) begin
                chk("hold_re", $signed(out_re), $signed(pre));
                chk("hold_im", $signed(out_im), $signed(pim));
            end
            chk("frame_done", frame_done, int'(out_valid && out_ready && idx == 3));
            if (frame_done) fd_cyc = cyc;
            if (out_valid && lat_pending) begin
                chk("latency", cyc - cyc_x3, 4);
                lat_pending = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bin", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("X%0d_re", idx), $signed(out_re), $signed(e.re));
                    chk($sformatf("X%0d_im", idx), $signed(out_im), $signed(e.im));
                end
                idx = (idx + 1) % 4;
            end
            pv = out_valid; pr = out_ready; pre = out_re; pim = out_im;
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_re = '0;
        in_im = '0;
        out_ready = 1'b1;
        @(negedge clk);
        do_reset();

        set_frame(1, 0, 0, 0, 0, 0, 0, 0);
        send_frame(0, 0);
        wait_idle();
        set_frame(0, 0, 1, 0, 0, 0, 0, 0);
        send_frame(1, 0);
        wait_idle();
        set_frame(100, 100, 100, 0, 100, 0, 100, 0);
        cur_im[0] = 9'd0; cur_im[1] = 9'd0;
        set_frame(100, 0, 100, 0, 100, 0, 100, 0);
        send_frame(0, 0);
        wait_idle();

        // Stall X1 for three cycles.
        rand_frame();
        send_frame(0, 0);
        wait_out_valid();
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        wait_idle();

        // Reset during CALC step 2, then a fresh frame with input gaps.
        rand_frame();
        send_frame(0, 0);
        repeat (2) @(negedge clk);
        do_reset();
        set_frame(2, 0, 0, 0, 0, 0, 0, 0);
        send_frame(1, 0);
        wait_idle();

        // Reset mid-LOAD.
        rand_frame();
        send_sample(0, 0);
        send_sample(1, 0);
        do_reset();
        rand_frame();
        send_frame(1, 0);
        wait_idle();

        // Reset mid-DRAIN.
        rand_frame();
        send_frame(0, 0);
        wait_out_valid();
        @(negedge clk);
        do_reset();
        rand_frame();
        send_frame(0, 0);
        wait_idle();

        // Back-to-back frames with in_valid held high.
        rand_frame();
        send_frame(0, 1);
        rand_frame();
        in_re = cur_re[0];
        in_im = cur_im[0];
        send_frame(0, 1);
        in_valid = 1'b0;
        chk("b2b_x0_after_done", acc_cyc - fd_cyc, 1);
        wait_idle();

        rnd_ready = 1;
        for (int f = 0; f < 20; f++) begin
            rand_frame();
            send_frame(1, 0);
        end
        wait_idle();
        rnd_ready = 0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
